// File: rtl/jogo_sequencia_unidade_controle_if.sv
// Handshake bundle between the sequence-game control unit and its datapath/top level.
// The slave side is the control unit; the master side drives the game inputs.
interface jogo_sequencia_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualLimite;
  logic       fimL;
  logic       zeraC;
  logic       contaC;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, igual, enderecoIgualLimite, fimL,
    input  zeraC, contaC, zeraL, contaL, zeraR, registraR,
    input  pronto, acertou, errou, db_timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, igual, enderecoIgualLimite, fimL,
    output zeraC, contaC, zeraL, contaL, zeraR, registraR,
    output pronto, acertou, errou, db_timeout, db_estado
  );
endinterface

// File: rtl/jogo_sequencia_unidade_controle.sv
// Moore control unit for the multi-round sequence game: sequences the address/limit
// counters and chaves register, edge-detects key presses and times out idle players.
module jogo_sequencia_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input logic clock,
  input logic reset,
  jogo_sequencia_unidade_controle_if.slave bus
);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // State encoding doubles as the 7-segment debug code.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_ERROU      = 4'hE,
    FIM_TIMEOUT    = 4'hD
  } state_t;

  state_t          state_q, state_d;
  logic            jogada_prev_q;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            jogada_ev;
  logic            tmo;

  logic zera_c, conta_c, zera_l, conta_l, zera_r, registra_r;
  logic pronto, acertou, errou, timeout;

  assign jogada_ev = bus.jogada & ~jogada_prev_q;
  assign tmo       = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d      = (state_q == ESPERA_JOGADA) ? wd_q + WD_W'(1) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= INICIAL;
      jogada_prev_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      jogada_prev_q <= bus.jogada;
      wd_q          <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        state_d = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     state_d = INICIO_RODADA;
      INICIO_RODADA:  state_d = ESPERA_JOGADA;
      // A fresh key press beats a watchdog expiry in the same cycle.
      ESPERA_JOGADA: begin
        if (jogada_ev)  state_d = REGISTRA;
        else if (tmo)   state_d = FIM_TIMEOUT;
        else            state_d = ESPERA_JOGADA;
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!bus.igual)                    state_d = FIM_ERROU;
        else if (!bus.enderecoIgualLimite) state_d = PROXIMA_JOGADA;
        else if (!bus.fimL)                state_d = PROXIMA_RODADA;
        else                               state_d = FIM_ACERTOU;
      end
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                      state_d = bus.iniciar ? PREPARACAO : state_q;
      default:        state_d = INICIAL;
    endcase
  end

  always_comb begin
    zera_c     = 1'b0;
    conta_c    = 1'b0;
    zera_l     = 1'b0;
    conta_l    = 1'b0;
    zera_r     = 1'b0;
    registra_r = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zera_c = 1'b1;
        zera_l = 1'b1;
        zera_r = 1'b1;
      end
      INICIO_RODADA:  zera_c     = 1'b1;
      REGISTRA:       registra_r = 1'b1;
      PROXIMA_JOGADA: conta_c    = 1'b1;
      PROXIMA_RODADA: conta_l    = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.zeraC      = zera_c;
  assign bus.contaC     = conta_c;
  assign bus.zeraL      = zera_l;
  assign bus.contaL     = conta_l;
  assign bus.zeraR      = zera_r;
  assign bus.registraR  = registra_r;
  assign bus.pronto     = pronto;
  assign bus.acertou    = acertou;
  assign bus.errou      = errou;
  assign bus.db_timeout = timeout;
  assign bus.db_estado  = state_q;
endmodule
